axi_ram_port_arb: RTL and testbench

//  Schedules a single-port RAM between the write-burst engine and the read-burst engine of an AXI RAM.

---
 rtl/axi_ram_port_arb.sv | 126 ++++++++++++
 tb/tb_axi_ram_port_arb.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ram_port_arb.sv
// Round-robin, per-burst arbiter that shares one single-port RAM between the
// write-burst and read-burst engines of an AXI RAM, with an optional beat limit per grant.
module axi_ram_port_arb #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 14,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int MAX_BEATS  = 16,
   parameter int WR_FIRST   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_req,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [STRB_WIDTH-1:0] wr_strb,
   input  logic                  wr_last,
   output logic                  wr_ack,
   input  logic                  rd_req,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic                  rd_last,
   output logic                  rd_ack,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_data_valid,
   output logic                  mem_en,
   output logic [STRB_WIDTH-1:0] mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] GNT_WR = 2'd1;
   localparam logic [1:0] GNT_RD = 2'd2;

   localparam logic LAST_RD = 1'b0;
   localparam logic LAST_WR = 1'b1;

   localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'((MAX_BEATS > 0) ? MAX_BEATS - 1 : 0);

   logic [1:0]       state;
   logic [1:0]       state_next;
   logic             last_grant;
   logic [CNT_W-1:0] beat_cnt;
   logic             rd_issue;

   logic wr_beat;
   logic rd_beat;
   logic at_limit;
   logic wr_handoff;
   logic rd_handoff;

   assign wr_ack  = (state == GNT_WR);
   assign rd_ack  = (state == GNT_RD);
   assign rd_data = mem_rdata;

   assign wr_beat    = wr_ack && wr_req;
   assign rd_beat    = rd_ack && rd_req;
   assign at_limit   = (MAX_BEATS != 0) && (beat_cnt == CNT_LIMIT);
   assign wr_handoff = wr_beat && (wr_last || at_limit);
   assign rd_handoff = rd_beat && (rd_last || at_limit);

   // A limit handoff with the other side idle keeps the grant; only a real last beat releases it.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (wr_req && rd_req)
               state_next = (last_grant == LAST_WR) ? GNT_RD : GNT_WR;
            else if (wr_req)
               state_next = GNT_WR;
            else if (rd_req)
               state_next = GNT_RD;
         end
         GNT_WR: begin
            if (wr_handoff) begin
               if (rd_req)       state_next = GNT_RD;
               else if (wr_last) state_next = IDLE;
            end
         end
         GNT_RD: begin
            if (rd_handoff) begin
               if (wr_req)       state_next = GNT_WR;
               else if (rd_last) state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: every register below is assigned with <= so all of them sample the same pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         last_grant    <= (WR_FIRST != 0) ? LAST_RD : LAST_WR;
         beat_cnt      <= '0;
         mem_en        <= 1'b0;
         mem_we        <= '0;
         rd_issue      <= 1'b0;
         rd_data_valid <= 1'b0;
      end else begin
         state <= state_next;
         if (wr_handoff || rd_handoff) begin
            last_grant <= wr_handoff ? LAST_WR : LAST_RD;
            beat_cnt   <= '0;
         end else if (wr_beat || rd_beat) begin
            beat_cnt <= beat_cnt + 1'b1;
         end
         mem_en        <= wr_beat || rd_beat;
         mem_we        <= wr_beat ? wr_strb : '0;
         rd_issue      <= rd_beat;
         rd_data_valid <= rd_issue;
      end
   end

   // NOTE: address and write data are qualified by mem_en downstream, so they carry no reset.
   always_ff @(posedge clk) begin
      if (wr_beat) begin
         mem_addr  <= wr_addr;
         mem_wdata <= wr_data;
      end else if (rd_beat) begin
         mem_addr <= rd_addr;
      end
   end

endmodule

// File: tb/tb_axi_ram_port_arb.sv
// Directed bench for axi_ram_port_arb: default, MAX_BEATS=4 and MAX_BEATS=0 instances
// share one stimulus; each section checks the instance it targets.
module tb_axi_ram_port_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_req, wr_last, rd_req, rd_last;
   logic [13:0] wr_addr, rd_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_strb;
   logic [31:0] zero_rdata = '0;

   logic        wr_ack, rd_ack, rd_data_valid, mem_en;
   logic [3:0]  mem_we;
   logic [13:0] mem_addr;
   logic [31:0] mem_wdata, rd_data, mem_rdata;

   logic        wr_ack4, rd_ack4, rd_data_valid4, mem_en4;
   logic [3:0]  mem_we4;
   logic [13:0] mem_addr4;
   logic [31:0] mem_wdata4, rd_data4;

   logic        wr_ack0, rd_ack0, rd_data_valid0, mem_en0;
   logic [3:0]  mem_we0;
   logic [13:0] mem_addr0;
   logic [31:0] mem_wdata0, rd_data0;

   logic [31:0] mem [0:16383];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   axi_ram_port_arb dut (
      .clk(clk), .rst(rst),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
      .wr_last(wr_last), .wr_ack(wr_ack),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_last(rd_last), .rd_ack(rd_ack),
      .rd_data(rd_data), .rd_data_valid(rd_data_valid),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   axi_ram_port_arb #(.MAX_BEATS(4)) dut4 (
      .clk(clk), .rst(rst),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
      .wr_last(wr_last), .wr_ack(wr_ack4),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_last(rd_last), .rd_ack(rd_ack4),
      .rd_data(rd_data4), .rd_data_valid(rd_data_valid4),
      .mem_en(mem_en4), .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
      .mem_rdata(zero_rdata)
   );

   axi_ram_port_arb #(.MAX_BEATS(0)) dut0 (
      .clk(clk), .rst(rst),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
      .wr_last(wr_last), .wr_ack(wr_ack0),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_last(rd_last), .rd_ack(rd_ack0),
      .rd_data(rd_data0), .rd_data_valid(rd_data_valid0),
      .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
      .mem_rdata(zero_rdata)
   );

   // Byte-enabled RAM with one cycle of read latency behind the default instance.
   always @(posedge clk) begin
      if (mem_en) begin
         for (int b = 0; b < 4; b++)
            if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         mem_rdata <= mem[mem_addr];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      wr_req  = 1'b0;
      rd_req  = 1'b0;
      wr_last = 1'b0;
      rd_last = 1'b0;
      wr_addr = '0;
      rd_addr = '0;
      wr_data = '0;
      wr_strb = 4'hF;
      tick();
      tick();
      rst = 1'b0;
   endtask

   bit is_wr4 [13] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 0};

   initial begin
      int wi;
      int ri;

      // Reset state
      do_reset();
      check("rst_wr_ack", 32'(wr_ack), 32'd0);
      check("rst_rd_ack", 32'(rd_ack), 32'd0);
      check("rst_mem_en", 32'(mem_en), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_rd_valid", 32'(rd_data_valid), 32'd0);

      // 1: 4-beat write burst at 0x10, one IDLE bubble, then back to IDLE
      wr_req = 1'b1; wr_addr = 14'h10; wr_data = 32'h1000;
      check("t1_bubble", 32'(wr_ack), 32'd0);
      tick();
      check("t1_grant", 32'(wr_ack), 32'd1);
      check("t1_no_en_yet", 32'(mem_en), 32'd0);
      for (int i = 0; i < 4; i++) begin
         wr_addr = 14'(16'h10 + i);
         wr_data = 32'h1000 + 32'(i);
         wr_last = (i == 3);
         tick();
         check("t1_en", 32'(mem_en), 32'd1);
         check("t1_we", 32'(mem_we), 32'hF);
         check("t1_addr", 32'(mem_addr), 32'h10 + 32'(i));
         check("t1_wdata", mem_wdata, 32'h1000 + 32'(i));
      end
      wr_req = 1'b0; wr_last = 1'b0;
      check("t1_idle_ack", 32'(wr_ack), 32'd0);
      tick();
      check("t1_idle_en", 32'(mem_en), 32'd0);

      // 2: write 0xDEADBEEF @0x20, read it back
      do_reset();
      wr_req = 1'b1; wr_addr = 14'h20; wr_data = 32'hDEADBEEF; wr_last = 1'b1;
      tick();
      tick();
      check("t2_wr_addr", 32'(mem_addr), 32'h20);
      wr_req = 1'b0; wr_last = 1'b0;
      rd_req = 1'b1; rd_addr = 14'h20; rd_last = 1'b1;
      tick();
      check("t2_rd_grant", 32'(rd_ack), 32'd1);
      tick();
      rd_req = 1'b0; rd_last = 1'b0;
      check("t2_rd_en", 32'(mem_en), 32'd1);
      check("t2_rd_we", 32'(mem_we), 32'd0);
      check("t2_rd_addr", 32'(mem_addr), 32'h20);
      check("t2_valid_early", 32'(rd_data_valid), 32'd0);
      tick();
      check("t2_valid", 32'(rd_data_valid), 32'd1);
      check("t2_rd_data", rd_data, 32'hDEADBEEF);
      tick();
      check("t2_valid_once", 32'(rd_data_valid), 32'd0);

      // 3: simultaneous requests, write wins the first tie, zero-bubble handoff
      do_reset();
      wr_req = 1'b1; wr_addr = 14'h40; rd_req = 1'b1; rd_addr = 14'h50;
      check("t3_bubble", 32'({wr_ack, rd_ack}), 32'd0);
      tick();
      check("t3_wr_first", 32'({wr_ack, rd_ack}), 32'b10);
      tick();
      check("t3_w0_addr", 32'(mem_addr), 32'h40);
      wr_addr = 14'h41; wr_last = 1'b1;
      tick();
      check("t3_w1_addr", 32'(mem_addr), 32'h41);
      check("t3_to_rd", 32'({wr_ack, rd_ack}), 32'b01);
      wr_req = 1'b0; wr_last = 1'b0;
      tick();
      check("t3_r0_addr", 32'(mem_addr), 32'h50);
      check("t3_r0_we", 32'(mem_we), 32'd0);
      rd_addr = 14'h51; rd_last = 1'b1;
      tick();
      check("t3_r1_addr", 32'(mem_addr), 32'h51);
      check("t3_idle", 32'({wr_ack, rd_ack}), 32'd0);
      rd_req = 1'b0; rd_last = 1'b0;
      tick();
      check("t3_idle_en", 32'(mem_en), 32'd0);

      // 4: MAX_BEATS=4, 10-beat write against a stream of 1-beat reads
      do_reset();
      wi = 0; ri = 0;
      wr_req = 1'b1; rd_req = 1'b1; rd_last = 1'b1;
      tick();
      for (int c = 0; c < 13; c++) begin
         wr_addr = 14'(16'h100 + wi);
         wr_data = 32'hA000 + 32'(wi);
         wr_last = (wi == 9);
         rd_addr = 14'(16'h200 + ri);
         check("t4_ack", 32'({wr_ack4, rd_ack4}), is_wr4[c] ? 32'b10 : 32'b01);
         tick();
         check("t4_en", 32'(mem_en4), 32'd1);
         if (is_wr4[c]) begin
            check("t4_w_addr", 32'(mem_addr4), 32'h100 + 32'(wi));
            check("t4_w_data", mem_wdata4, 32'hA000 + 32'(wi));
            check("t4_w_we", 32'(mem_we4), 32'hF);
            wi++;
         end else begin
            check("t4_r_addr", 32'(mem_addr4), 32'h200 + 32'(ri));
            check("t4_r_we", 32'(mem_we4), 32'd0);
            ri++;
         end
         if (wi == 10) begin
            wr_req  = 1'b0;
            wr_last = 1'b0;
         end
      end
      rd_req = 1'b0; rd_last = 1'b0;
      check("t4_idle", 32'({wr_ack4, rd_ack4}), 32'd0);
      tick();
      check("t4_idle_en", 32'(mem_en4), 32'd0);

      // 5: MAX_BEATS=0, 256-beat write keeps the pending read waiting
      do_reset();
      wr_req = 1'b1; rd_req = 1'b1; rd_addr = 14'h3F0; rd_last = 1'b1;
      tick();
      for (int i = 0; i < 256; i++) begin
         wr_addr = 14'(i);
         wr_last = (i == 255);
         check("t5_ack", 32'({wr_ack0, rd_ack0}), 32'b10);
         tick();
         check("t5_w_addr", 32'(mem_addr0), 32'(i));
      end
      wr_req = 1'b0; wr_last = 1'b0;
      check("t5_rd_grant", 32'({wr_ack0, rd_ack0}), 32'b01);
      tick();
      check("t5_r_addr", 32'(mem_addr0), 32'h3F0);
      check("t5_r_we", 32'(mem_we0), 32'd0);
      rd_req = 1'b0; rd_last = 1'b0;

      // 6: write gap holds the grant, then reset mid read burst
      do_reset();
      wr_req = 1'b1; wr_addr = 14'h300;
      tick();
      tick();
      check("t6_w0_addr", 32'(mem_addr), 32'h300);
      wr_req = 1'b0;
      for (int g = 0; g < 3; g++) begin
         tick();
         check("t6_gap_ack", 32'(wr_ack), 32'd1);
         check("t6_gap_en", 32'(mem_en), 32'd0);
      end
      wr_req = 1'b1; wr_addr = 14'h301; wr_last = 1'b1;
      tick();
      check("t6_w1_en", 32'(mem_en), 32'd1);
      check("t6_w1_addr", 32'(mem_addr), 32'h301);
      wr_req = 1'b0; wr_last = 1'b0;
      rd_req = 1'b1; rd_addr = 14'h20;
      tick();
      check("t6_rd_grant", 32'(rd_ack), 32'd1);
      tick();
      rd_addr = 14'h21;
      tick();
      check("t6_inflight", 32'(rd_data_valid), 32'd1);
      rst = 1'b1;
      tick();
      check("t6_rst_outs", 32'({wr_ack, rd_ack, mem_en, rd_data_valid}), 32'd0);
      check("t6_rst_we", 32'(mem_we), 32'd0);
      rst = 1'b0; rd_req = 1'b0;
      tick();
      check("t6_dropped", 32'(rd_data_valid), 32'd0);
      check("t6_idle", 32'({wr_ack, rd_ack, mem_en}), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
